// File: rtl/bb_boot_copier.sv
// Boot copier: moves WORDS words from SRC_BASE to DST_BASE over the Blackbone bus, holding the CPU in reset until done.
// Optional running checksum and mismatch flag enabled by defining BB_BOOT_COPIER_CHECKSUM_EN.
module bb_boot_copier #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   SRC_BASE = 32'h0000_0000,
    parameter logic [AW-1:0]   DST_BASE = 32'h0000_1000,
    parameter int              WORDS    = 64,
    parameter logic [DW-1:0]   EXP_SUM  = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic [AW-1:0] bb_addr_o,
    output logic [DW-1:0] bb_dout_o,
    output logic          bb_en_o,
    output logic          bb_we_o,
    input  logic [DW-1:0] bb_din_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          cpu_rst_o,
    output logic [DW-1:0] checksum_o,
    output logic          err_o
);
    // Index must reach WORDS itself after the final increment.
    localparam int            IW   = (WORDS < 1) ? 1 : $clog2(WORDS + 1);
    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] data_q;
    logic          launch;
    logic          last_word;

    assign launch    = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign last_word = (32'(idx_q) + 32'd1) >= 32'(WORDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            if (launch)                idx_q <= '0;
            else if (state_q == S_WR)  idx_q <= idx_q + 1'b1;
            if (state_q == S_CAP)      data_q <= bb_din_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        bb_en_o   = 1'b0;
        bb_we_o   = 1'b0;
        bb_addr_o = '0;
        bb_dout_o = '0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done_o = (state_q == S_DONE);
                // An empty copy completes without touching the bus, also on restart.
                if (start_i) state_d = (WORDS == 0) ? S_DONE : S_RD;
            end
            S_RD: begin
                busy_o    = 1'b1;
                bb_en_o   = 1'b1;
                bb_addr_o = SRC_BASE + STEP * AW'(idx_q);
                state_d   = S_CAP;
            end
            S_CAP: begin
                busy_o  = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                busy_o    = 1'b1;
                bb_en_o   = 1'b1;
                bb_we_o   = 1'b1;
                bb_addr_o = DST_BASE + STEP * AW'(idx_q);
                bb_dout_o = data_q;
                state_d   = last_word ? S_DONE : S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_rst_o = !done_o || err_o;

`ifdef BB_BOOT_COPIER_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    sum_q <= '0;
        else if (launch)            sum_q <= '0;
        else if (state_q == S_CAP)  sum_q <= sum_q + bb_din_i;
    end

    assign checksum_o = sum_q;
    assign err_o      = (state_q == S_DONE) && (sum_q != EXP_SUM);
`else
    // Constant zero; EXP_SUM is folded in only so the parameter stays referenced.
    assign checksum_o = '0;
    assign err_o      = 1'b0 & (^EXP_SUM);
`endif

endmodule

// File: tb/tb_bb_boot_copier.sv
// Bench for bb_boot_copier: four parameterisations share clock, reset and start, each with its own bus responder.
// Expected writes, timing and checksum come from a word-level model of the copy.
module tb_bb_boot_copier;
`ifdef BB_BOOT_COPIER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr_s [4];
    logic [31:0] dout_s [4];
    logic [31:0] din_s  [4];
    logic [31:0] cks_s  [4];
    logic        en_s   [4];
    logic        we_s   [4];
    logic        busy_s [4];
    logic        done_s [4];
    logic        crst_s [4];
    logic        err_s  [4];

    int          checks = 0;
    int          failures = 0;
    int          mode = 0;
    logic [31:0] rnd [64];
    logic [31:0] wa [4][32];
    logic [31:0] wd [4][32];
    int          wcnt [4];
    int          acc [4];

    always #5 clk = ~clk;

    bb_boot_copier #(.SRC_BASE(32'h0), .DST_BASE(32'h1000), .WORDS(4), .EXP_SUM(32'd10)) u0 (
        .clk(clk), .rst(rst), .start_i(start), .bb_addr_o(addr_s[0]), .bb_dout_o(dout_s[0]),
        .bb_en_o(en_s[0]), .bb_we_o(we_s[0]), .bb_din_i(din_s[0]), .busy_o(busy_s[0]),
        .done_o(done_s[0]), .cpu_rst_o(crst_s[0]), .checksum_o(cks_s[0]), .err_o(err_s[0]));
    bb_boot_copier #(.SRC_BASE(32'h0), .DST_BASE(32'h1000), .WORDS(4), .EXP_SUM(32'd11)) u1 (
        .clk(clk), .rst(rst), .start_i(start), .bb_addr_o(addr_s[1]), .bb_dout_o(dout_s[1]),
        .bb_en_o(en_s[1]), .bb_we_o(we_s[1]), .bb_din_i(din_s[1]), .busy_o(busy_s[1]),
        .done_o(done_s[1]), .cpu_rst_o(crst_s[1]), .checksum_o(cks_s[1]), .err_o(err_s[1]));
    bb_boot_copier #(.SRC_BASE(32'h0), .DST_BASE(32'h1000), .WORDS(0), .EXP_SUM(32'd0)) u2 (
        .clk(clk), .rst(rst), .start_i(start), .bb_addr_o(addr_s[2]), .bb_dout_o(dout_s[2]),
        .bb_en_o(en_s[2]), .bb_we_o(we_s[2]), .bb_din_i(din_s[2]), .busy_o(busy_s[2]),
        .done_o(done_s[2]), .cpu_rst_o(crst_s[2]), .checksum_o(cks_s[2]), .err_o(err_s[2]));
    bb_boot_copier #(.SRC_BASE(32'hFFFF_FFF0), .DST_BASE(32'hFFFF_FFF8), .WORDS(7), .EXP_SUM(32'd0)) u3 (
        .clk(clk), .rst(rst), .start_i(start), .bb_addr_o(addr_s[3]), .bb_dout_o(dout_s[3]),
        .bb_en_o(en_s[3]), .bb_we_o(we_s[3]), .bb_din_i(din_s[3]), .busy_o(busy_s[3]),
        .done_o(done_s[3]), .cpu_rst_o(crst_s[3]), .checksum_o(cks_s[3]), .err_o(err_s[3]));

    function automatic int w_of(input int k);
        case (k) 0, 1: return 4; 2: return 0; default: return 7; endcase
    endfunction
    function automatic logic [31:0] src_of(input int k);
        return (k == 3) ? 32'hFFFF_FFF0 : 32'h0;
    endfunction
    function automatic logic [31:0] dst_of(input int k);
        return (k == 3) ? 32'hFFFF_FFF8 : 32'h1000;
    endfunction
    function automatic logic [31:0] exp_of(input int k);
        return (k == 0) ? 32'd10 : (k == 1) ? 32'd11 : 32'd0;
    endfunction

    function automatic logic [31:0] resp(input logic [31:0] a);
        case (mode)
            0:       return a + 32'hA5;
            1:       return (a >> 2) + 32'd1;
            default: return rnd[a[7:2]];
        endcase
    endfunction

    // Memory returns read data one cycle after a read access.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (en_s[k] && !we_s[k]) din_s[k] <= resp(addr_s[k]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_en%0d", tag, k), 32'(en_s[k]), 32'd0);
            chk($sformatf("%s_we%0d", tag, k), 32'(we_s[k]), 32'd0);
            chk($sformatf("%s_addr%0d", tag, k), addr_s[k], 32'd0);
            chk($sformatf("%s_dout%0d", tag, k), dout_s[k], 32'd0);
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy_s[k]), 32'd0);
            chk($sformatf("%s_done%0d", tag, k), 32'(done_s[k]), 32'd0);
            chk($sformatf("%s_cpurst%0d", tag, k), 32'(crst_s[k]), 32'd1);
            chk($sformatf("%s_cks%0d", tag, k), cks_s[k], 32'd0);
            chk($sformatf("%s_err%0d", tag, k), 32'(err_s[k]), 32'd0);
        end
    endtask

    task automatic log_access();
        for (int k = 0; k < 4; k++) begin
            if (en_s[k]) acc[k]++;
            if (en_s[k] && we_s[k] && wcnt[k] < 32) begin
                wa[k][wcnt[k]] = addr_s[k];
                wd[k][wcnt[k]] = dout_s[k];
                wcnt[k]++;
            end
        end
    endtask

    // c counts rising edges after the edge that sampled start (that edge is c=0).
    task automatic run_copy(input int md, input int restart_at, input int rst_at, input string tag);
        int snap [4];
        mode = md;
        for (int k = 0; k < 4; k++) begin wcnt[k] = 0; acc[k] = 0; end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) @(negedge clk);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                chk_reset({tag, "_rst"});
                for (int k = 0; k < 4; k++) snap[k] = acc[k];
                @(negedge clk); rst = 1'b0;
                repeat (4) begin @(negedge clk); log_access(); end
                for (int k = 0; k < 4; k++)
                    chk($sformatf("%s_noacc%0d", tag, k), 32'(acc[k]), 32'(snap[k]));
                chk_reset({tag, "_idle"});
                return;
            end
            log_access();
            for (int k = 0; k < 4; k++) begin
                if (c == 3 * w_of(k)) begin
                    chk($sformatf("%s_done_at%0d", tag, k), 32'(done_s[k]), 32'd1);
                    chk($sformatf("%s_busy_at%0d", tag, k), 32'(busy_s[k]), 32'd0);
                end
                if (c == 3 * w_of(k) - 1) begin
                    chk($sformatf("%s_done_pre%0d", tag, k), 32'(done_s[k]), 32'd0);
                    chk($sformatf("%s_busy_pre%0d", tag, k), 32'(busy_s[k]), 32'd1);
                end
            end
            start = (c == restart_at);
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] sum = 32'd0;
            logic        e;
            for (int j = 0; j < w_of(k); j++) sum += resp(src_of(k) + 32'(4 * j));
            if (!CK_EN) sum = 32'd0;
            e = CK_EN && (sum != exp_of(k));
            chk($sformatf("%s_nwr%0d", tag, k), 32'(wcnt[k]), 32'(w_of(k)));
            chk($sformatf("%s_nacc%0d", tag, k), 32'(acc[k]), 32'(2 * w_of(k)));
            for (int j = 0; j < w_of(k) && j < wcnt[k]; j++) begin
                chk($sformatf("%s_wa%0d_%0d", tag, k, j), wa[k][j], dst_of(k) + 32'(4 * j));
                chk($sformatf("%s_wd%0d_%0d", tag, k, j), wd[k][j], resp(src_of(k) + 32'(4 * j)));
            end
            chk($sformatf("%s_cks%0d", tag, k), cks_s[k], sum);
            chk($sformatf("%s_err%0d", tag, k), 32'(err_s[k]), 32'(e));
            chk($sformatf("%s_cpurst%0d", tag, k), 32'(crst_s[k]), 32'(e));
            chk($sformatf("%s_done%0d", tag, k), 32'(done_s[k]), 32'd1);
            chk($sformatf("%s_en_done%0d", tag, k), 32'(en_s[k]), 32'd0);
            chk($sformatf("%s_addr_done%0d", tag, k), addr_s[k], 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    initial begin
        wr_t basic_tbl [4];
        basic_tbl[0] = '{32'h1000, 32'hA5};
        basic_tbl[1] = '{32'h1004, 32'hA9};
        basic_tbl[2] = '{32'h1008, 32'hAD};
        basic_tbl[3] = '{32'h100C, 32'hB1};
        for (int i = 0; i < 64; i++) rnd[i] = 32'd0;

        #1 chk_reset("por");
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("idle");

        run_copy(0, -1, -1, "basic");
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("tbl_addr%0d", j), wa[0][j], basic_tbl[j].addr);
            chk($sformatf("tbl_data%0d", j), wd[0][j], basic_tbl[j].data);
        end

        run_copy(0, 5, -1, "busy_start");
        run_copy(0, -1, 7, "mid_rst");
        run_copy(0, -1, -1, "after_rst");
        run_copy(1, -1, -1, "cksum");

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 64; i++) rnd[i] = $urandom;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_copy(2, (it % 2 == 1) ? int'($urandom_range(1, 10)) : -1, -1, $sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bb_boot_copier.md
BB_BOOT_COPIER -- requirements
Module: bb_boot_copier

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
- AW, 32, address width
- DW, 32, data width
- SRC_BASE, 32'h0000_0000, first source byte address
- DST_BASE, 32'h0000_1000, first destination byte address
- WORDS, 64, words to copy
- EXP_SUM, 32'h0, expected checksum
REQ-002 Ports, one per line (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock
- rst, in, 1, reset
- start_i, in, 1, copy request pulse
- bb_addr_o, out, AW, bus byte address
- bb_dout_o, out, DW, write data
- bb_en_o, out, 1, access enable
- bb_we_o, out, 1, write enable
- bb_din_i, in, DW, read data
- busy_o, out, 1, copy in progress
- done_o, out, 1, copy complete
- cpu_rst_o, out, 1, CPU held in reset
- checksum_o, out, DW, running word sum
- err_o, out, 1, checksum mismatch
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-004 The block SHALL act as the initiator on the Blackbone bus. Read data SHALL be valid on bb_din_i one cycle after a read access (bb_en_o=1, bb_we_o=0).

Function
REQ-005 The state machine SHALL have these states:
- IDLE: no access.
- RD: bb_en_o=1, bb_we_o=0, bb_addr_o=SRC_BASE+(DW/8)*i.
- CAP: bb_en_o=0; bb_din_i latched into the data register.
- WR: bb_en_o=1, bb_we_o=1, bb_addr_o=DST_BASE+(DW/8)*i, bb_dout_o=data register.
- DONE: no access.
REQ-006 Transitions SHALL be:
- IDLE->RD on start_i=1, with word index i cleared to 0.
- RD->CAP->WR unconditionally.
- WR->RD with i+1 if i<WORDS-1, else WR->DONE.
REQ-007 If WORDS=0, IDLE SHALL go directly to DONE on start_i, with no bus access.
REQ-008 Each word SHALL take exactly 3 cycles. DONE SHALL be entered on the 3*WORDS-th rising edge after the edge that sampled start_i.
REQ-009 start_i SHALL be ignored in RD, CAP and WR. In DONE, start_i=1 SHALL restart the copy (go to RD with i=0, cpu_rst_o=1).
REQ-010 Address arithmetic SHALL be modulo 2^AW; wrap-around is permitted and not flagged.
REQ-011 busy_o SHALL be 1 in RD, CAP and WR. done_o SHALL be 1 only in DONE. cpu_rst_o SHALL be 0 only in DONE.
REQ-012 Outputs SHALL be decoded from the state and registers only; there SHALL be no combinational path from bb_din_i or start_i to any output.
REQ-013 In IDLE and DONE, bb_en_o, bb_we_o, bb_addr_o and bb_dout_o SHALL be 0.
REQ-014 The index counter SHALL be wide enough to hold WORDS without overflow.

Reset
REQ-015 On rst=1, the following SHALL hold immediately, regardless of the clock:
- state=IDLE, i=0, data register=0
- bb_en_o=0, bb_we_o=0, bb_addr_o=0, bb_dout_o=0
- busy_o=0, done_o=0, cpu_rst_o=1
- checksum_o=0, err_o=0
REQ-016 Reset asserted mid-copy SHALL abort with no further bus access. A new start_i SHALL be required after reset release.

Configuration
REQ-017 With macro BB_BOOT_COPIER_CHECKSUM_EN defined:
- checksum_o SHALL clear on the start_i acceptance.
- In CAP, checksum_o SHALL add bb_din_i modulo 2^DW.
- err_o SHALL be 1 in DONE when checksum_o != EXP_SUM.
- cpu_rst_o SHALL remain 1 while err_o=1.
REQ-018 Without the macro, checksum_o and err_o SHALL be tied 0 and no adder SHALL be synthesised.

Verification
REQ-019 Basic copy: WORDS=4, SRC=0x0, DST=0x1000, responder returns data=addr+0xA5 -> writes 0xA5@0x1000, 0xA9@0x1004, 0xAD@0x1008, 0xB1@0x100C; done_o rises 12 edges after start.
REQ-020 Empty copy: WORDS=0, start_i pulse -> no bb_en_o activity; done_o=1 and cpu_rst_o=0 one edge after start.
REQ-021 Start while busy: WORDS=4, second start_i at cycle 5 -> ignored; exactly 4 writes occur, done at edge 12.
REQ-022 Mid-copy reset: rst at cycle 7 -> outputs reset immediately, cpu_rst_o=1, no access until a new start; the new copy completes normally.
REQ-023 Checksum (macro defined): WORDS=4, data 1, 2, 3, 4 -> checksum_o=10. With EXP_SUM=10: err_o=0, cpu_rst_o=0. With EXP_SUM=11: err_o=1, cpu_rst_o=1.
REQ-024 Checksum (macro undefined): the same stimulus -> checksum_o=0, err_o=0, cpu_rst_o=0 in DONE.
